madd_err_sweeper: RTL and testbench

Exhaustive error-evaluation controller for small approximate adders of the `madd_iX_oY` family. On `start` it sweeps every input vector through an attached combinational adder under test, one vector per cycle. It compares each result against the exact sum and accumulates error statistics: error count, sum and maximum of absolute error, and the index of the first failing vector. It replaces file-driven vector benches for on-chip and in-simulation characterisation. It sits beside the adder under test, driving its `pi` pins and reading its `po` pins.

---
 rtl/madd_err_sweeper.sv | 100 ++++++++++
 tb/tb_madd_err_sweeper.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/madd_err_sweeper.sv
// Exhaustive error sweeper for small approximate adders: drives every input vector
// once and accumulates error count, sum/max of absolute error and first failing index.
module madd_err_sweeper #(
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [2*W-1:0]   pi_o,
    input  logic [W:0]       po_i,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [3*W+1:0]   sum_abs_err,
    output logic [W:0]       max_abs_err,
    output logic [2*W-1:0]   first_err_vec,
    output logic             first_err_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [2*W-1:0]   cnt_reg;
    logic [2*W:0]     err_count_reg;
    logic [3*W+1:0]   sum_abs_err_reg;
    logic [W:0]       max_abs_err_reg;
    logic [2*W-1:0]   first_err_vec_reg;
    logic             first_err_valid_reg;

    logic             accept;
    logic             last_vec;
    logic [W:0]       exact;
    logic [W:0]       diff;

    assign accept   = (state_reg == IDLE) && start;
    assign last_vec = &cnt_reg;

    // Operands are zero-extended by one bit so the exact sum never overflows.
    always_comb begin
        exact = {1'b0, cnt_reg[W-1:0]} + {1'b0, cnt_reg[2*W-1:W]};
        diff  = (po_i >= exact) ? (po_i - exact) : (exact - po_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_vec) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cnt_reg             <= '0;
            err_count_reg       <= '0;
            sum_abs_err_reg     <= '0;
            max_abs_err_reg     <= '0;
            first_err_vec_reg   <= '0;
            first_err_valid_reg <= 1'b0;
        end else if (state_reg == RUN) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (diff != '0) begin
                err_count_reg   <= err_count_reg + 1'b1;
                sum_abs_err_reg <= sum_abs_err_reg + {{(2*W+1){1'b0}}, diff};
                if (!first_err_valid_reg) begin
                    first_err_vec_reg   <= cnt_reg;
                    first_err_valid_reg <= 1'b1;
                end
            end
            if (diff > max_abs_err_reg) begin
                max_abs_err_reg <= diff;
            end
        end
    end

    // The adder only sees the live counter while sweeping; otherwise it is parked at 0.
    assign pi_o            = (state_reg == RUN) ? cnt_reg : '0;
    assign busy            = (state_reg == RUN);
    assign done            = (state_reg == FIN);
    assign err_count       = err_count_reg;
    assign sum_abs_err     = sum_abs_err_reg;
    assign max_abs_err     = max_abs_err_reg;
    assign first_err_vec   = first_err_vec_reg;
    assign first_err_valid = first_err_valid_reg;

endmodule

// File: tb/tb_madd_err_sweeper.sv
// Bench for madd_err_sweeper (W=3): behavioural adder models, a cycle-indexed
// reference model checked every cycle, and literal checks of known sweep results.
module tb_madd_err_sweeper;

    localparam int W    = 3;
    localparam int NV   = 1 << (2 * W);
    localparam logic [1:0] M_EXACT = 2'd0;
    localparam logic [1:0] M_STUCK = 2'd1;
    localparam logic [1:0] M_LSB   = 2'd2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] pi_o;
    logic [W:0]     po_i;
    logic           busy;
    logic           done;
    logic [2*W:0]   err_count;
    logic [3*W+1:0] sum_abs_err;
    logic [W:0]     max_abs_err;
    logic [2*W-1:0] first_err_vec;
    logic           first_err_valid;
    logic [1:0]     mode;

    int n_vec  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    madd_err_sweeper #(.W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pi_o            (pi_o),
        .po_i            (po_i),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .sum_abs_err     (sum_abs_err),
        .max_abs_err     (max_abs_err),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    always #5 clk = ~clk;

    function automatic int adder_out(input logic [1:0] m, input int v);
        int a, b;
        a = v % (1 << W);
        b = v / (1 << W);
        case (m)
            M_STUCK: return 0;
            M_LSB:   return (a + b) & ~1;
            default: return a + b;
        endcase
    endfunction

    assign po_i = (W+1)'(adder_out(mode, int'(pi_o)));

    // Statistics over the first n vectors, straight from the definitions.
    task automatic sweep_stats(input logic [1:0] m, input int n,
                               output int ec, output int sae, output int mae,
                               output int fev, output int fvalid);
        int d;
        ec = 0; sae = 0; mae = 0; fev = 0; fvalid = 0;
        for (int v = 0; v < n; v++) begin
            d = adder_out(m, v) - ((v % (1 << W)) + (v / (1 << W)));
            if (d < 0) d = -d;
            if (d != 0) begin
                ec++;
                sae += d;
                if (fvalid == 0) begin
                    fev = v;
                    fvalid = 1;
                end
            end
            if (d > mae) mae = d;
        end
    endtask

    // Model: cycle counter plus the cycle index at which the current sweep was accepted.
    int cyc = 0;
    int s_acc = -1;
    logic [1:0] m_mode = M_EXACT;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            s_acc <= -1;
        end else if (start && (s_acc < 0 || (cyc - s_acc) >= NV + 2)) begin
            s_acc  <= cyc;
            m_mode <= mode;
        end
    end

    always @(negedge clk) begin
        int k, n, ec, sae, mae, fev, fvalid;
        logic e_busy, e_done;
        int e_pi;
        if (checking) begin
            if (s_acc < 0) begin
                n = 0; e_busy = 1'b0; e_done = 1'b0; e_pi = 0;
            end else begin
                k      = cyc - s_acc;
                e_busy = (k >= 1) && (k <= NV);
                e_done = (k == NV + 1);
                e_pi   = e_busy ? k - 1 : 0;
                n      = (k <= NV) ? k - 1 : NV;
            end
            sweep_stats(m_mode, n, ec, sae, mae, fev, fvalid);
            n_vec++;
            if (busy !== e_busy) begin
                n_fail++; $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, e_busy);
            end
            if (done !== e_done) begin
                n_fail++; $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, done, e_done);
            end
            if (pi_o !== (2*W)'(e_pi)) begin
                n_fail++; $display("FAIL pi_o cyc=%0d got=%0d exp=%0d", cyc, pi_o, e_pi);
            end
            if (err_count !== (2*W+1)'(ec)) begin
                n_fail++; $display("FAIL err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, ec);
            end
            if (sum_abs_err !== (3*W+2)'(sae)) begin
                n_fail++; $display("FAIL sum_abs_err cyc=%0d got=%0d exp=%0d", cyc, sum_abs_err, sae);
            end
            if (max_abs_err !== (W+1)'(mae)) begin
                n_fail++; $display("FAIL max_abs_err cyc=%0d got=%0d exp=%0d", cyc, max_abs_err, mae);
            end
            if (first_err_vec !== (2*W)'(fev)) begin
                n_fail++; $display("FAIL first_err_vec cyc=%0d got=%0d exp=%0d", cyc, first_err_vec, fev);
            end
            if (first_err_valid !== fvalid[0]) begin
                n_fail++; $display("FAIL first_err_valid cyc=%0d got=%0b exp=%0d", cyc, first_err_valid, fvalid);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
        $display("check %s = %0d (expected %0d)", name, act, exp);
    endtask

    task automatic check_stats(input string tag, input int ec, input int sae, input int mae,
                               input int fev, input int fvalid);
        lit({tag, ".err_count"}, int'(err_count), ec);
        lit({tag, ".sum_abs_err"}, int'(sum_abs_err), sae);
        lit({tag, ".max_abs_err"}, int'(max_abs_err), mae);
        lit({tag, ".first_err_vec"}, int'(first_err_vec), fev);
        lit({tag, ".first_err_valid"}, int'(first_err_valid), fvalid);
    endtask

    task automatic run_sweep(input logic [1:0] m, input string tag);
        int lat;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        lat   = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        lit({tag, ".latency"}, lat, NV + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec, sae, mae, fev, fvalid;
        int dones, dc, d1, d2;

        // Pin the reference model against hand-computed sweep results.
        sweep_stats(M_STUCK, NV, ec, sae, mae, fev, fvalid);
        lit("model.stuck.err_count", ec, 63);
        lit("model.stuck.sum_abs_err", sae, 448);
        lit("model.stuck.max_abs_err", mae, 14);
        sweep_stats(M_LSB, NV, ec, sae, mae, fev, fvalid);
        lit("model.lsb.err_count", ec, 32);
        lit("model.lsb.first_err_vec", fev, 1);

        rst   = 1'b1;
        start = 1'b0;
        mode  = M_EXACT;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        lit("reset.busy", int'(busy), 0);
        lit("reset.done", int'(done), 0);
        lit("reset.pi_o", int'(pi_o), 0);
        check_stats("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        run_sweep(M_EXACT, "exact");
        check_stats("exact", 0, 0, 0, 0, 0);

        run_sweep(M_STUCK, "stuck");
        check_stats("stuck", 63, 448, 14, 1, 1);

        run_sweep(M_LSB, "lsb");
        check_stats("lsb", 32, 32, 1, 1, 1);

        // Reset in cycle 20 of a sweep.
        @(negedge clk);
        mode  = M_STUCK;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        lit("midrst.busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        lit("midrst.busy", int'(busy), 0);
        lit("midrst.done", int'(done), 0);
        lit("midrst.pi_o", int'(pi_o), 0);
        check_stats("midrst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        run_sweep(M_STUCK, "after_rst");
        check_stats("after_rst", 63, 448, 14, 1, 1);

        // start pulses in cycles 10 and 65 must not restart the sweep.
        @(negedge clk);
        mode  = M_LSB;
        start = 1'b1;
        dones = 0;
        dc    = -1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = (c == 10) || (c == NV + 1);
            if (done) begin
                dones++;
                dc = c;
            end
        end
        start = 1'b0;
        lit("restart.done_count", dones, 1);
        lit("restart.done_cycle", dc, NV + 1);
        check_stats("restart", 32, 32, 1, 1, 1);

        // Back-to-back: stuck-at-0 then exact, start held high.
        @(negedge clk);
        mode  = M_STUCK;
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (c == NV + 2) mode = M_EXACT;
            if (c == NV + 3) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check_stats("b2b_first", 63, 448, 14, 1, 1);
                end else if (d2 < 0) begin
                    d2 = c;
                end
            end
        end
        start = 1'b0;
        lit("b2b.first_done", d1, NV + 1);
        lit("b2b.second_done", d2, 2 * NV + 3);
        check_stats("b2b_second", 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
